// File: rtl/rf_pkg.sv
// Shared register-file constants and the address-to-bitmap decode used by
// writeback hazard tracking.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 64;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

    // One-hot decode of a destination register; XZR never shows as pending.
    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (rd != XZR) m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous request FIFO for the writeback sequencer; exposes per-entry
// valid flags and each entry's tag field so the owner can decode hazards.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 139,
    parameter int unsigned TAG_W = 11
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH)-1:0]   head_idx,
    output logic [DEPTH-1:0]           entry_valid,
    output logic [DEPTH*TAG_W-1:0]     tags
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (wr_ptr == rd_ptr);
    assign head     = mem[rd_ptr[AW-1:0]];
    assign head_idx = rd_ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [AW-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        tags        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset         = AW'(i) - rd_ptr[AW-1:0];
            entry_valid[i] = ({1'b0, offset} < count);
            tags[i*TAG_W +: TAG_W] = mem[i][WIDTH-1 -: TAG_W];
        end
    end

endmodule

// File: rtl/reg_writeback_seq.sv
// Register-file write initiator: queues single/pair writeback requests and
// serialises them into one registered write per cycle, skipping XZR.
module reg_writeback_seq
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [4:0]        ReqRd0,
    input  logic [DATA_W-1:0] ReqData0,
    input  logic              ReqPair,
    input  logic [4:0]        ReqRd1,
    input  logic [DATA_W-1:0] ReqData1,
    output logic [4:0]        RW,
    output logic [DATA_W-1:0] BusW,
    output logic              RegWr,
    output logic [31:0]       Pending,
    output logic              Busy
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned TAG_W = 11;
    localparam int unsigned EW    = 2*DATA_W + TAG_W;

    // Entry layout {rd0, pair, rd1, data0, data1}: the tag sits on top so the
    // FIFO can export just the bits the Pending decode needs.
    localparam int unsigned D1_LSB   = 0;
    localparam int unsigned D0_LSB   = DATA_W;
    localparam int unsigned RD1_LSB  = 2*DATA_W;
    localparam int unsigned PAIR_BIT = 2*DATA_W + 5;
    localparam int unsigned RD0_LSB  = 2*DATA_W + 6;

    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [EW-1:0]          head;
    logic [AW-1:0]          head_idx;
    logic [DEPTH-1:0]       entry_valid;
    logic [DEPTH*TAG_W-1:0] tags;

    logic                   phase;
    logic                   phase_next;
    logic                   issue;
    logic [4:0]             issue_rd;
    logic [DATA_W-1:0]      issue_data;

    logic [4:0]             h_rd0;
    logic [4:0]             h_rd1;
    logic                   h_pair;
    logic                   live0;
    logic                   live1;

    assign ReqReady = !full;
    assign push     = ReqValid && !full;
    assign Busy     = !empty || RegWr;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk         (Clk),
        .reset       (Reset),
        .push        (push),
        .push_data   ({ReqRd0, ReqPair, ReqRd1, ReqData0, ReqData1}),
        .pop         (pop),
        .full        (full),
        .empty       (empty),
        .head        (head),
        .head_idx    (head_idx),
        .entry_valid (entry_valid),
        .tags        (tags)
    );

    assign h_rd0  = head[RD0_LSB +: 5];
    assign h_rd1  = head[RD1_LSB +: 5];
    assign h_pair = head[PAIR_BIT];
    assign live0  = (h_rd0 != XZR);
    assign live1  = h_pair && (h_rd1 != XZR);

    always_comb begin
        issue      = 1'b0;
        issue_rd   = h_rd0;
        issue_data = head[D0_LSB +: DATA_W];
        pop        = 1'b0;
        phase_next = phase;
        if (!empty) begin
            if (phase) begin
                issue      = 1'b1;
                issue_rd   = h_rd1;
                issue_data = head[D1_LSB +: DATA_W];
                pop        = 1'b1;
                phase_next = 1'b0;
            end else if (live0) begin
                issue = 1'b1;
                if (live1) phase_next = 1'b1;
                else       pop        = 1'b1;
            end else begin
                // Dead slot 0: slot 1 (if live) goes out now, else the entry retires silently.
                pop = 1'b1;
                if (live1) begin
                    issue      = 1'b1;
                    issue_rd   = h_rd1;
                    issue_data = head[D1_LSB +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegWr <= 1'b0;
            RW    <= XZR;
            BusW  <= '0;
            phase <= 1'b0;
        end else begin
            RegWr <= issue;
            if (issue) begin
                RW   <= issue_rd;
                BusW <= issue_data;
            end
            phase <= phase_next;
        end
    end

    // The head's slot 0 has already left when phase is set; the output register covers it.
    always_comb begin
        logic [TAG_W-1:0] t;
        t       = '0;
        Pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            t = tags[i*TAG_W +: TAG_W];
            if (entry_valid[i]) begin
                if (!(phase && (AW'(i) == head_idx))) Pending = Pending | reg_bit(t[10:6]);
                if (t[5]) Pending = Pending | reg_bit(t[4:0]);
            end
        end
        if (RegWr) Pending = Pending | reg_bit(RW);
    end

endmodule

// File: tb/tb_reg_writeback_seq.sv
// Randomised self-checking bench for reg_writeback_seq against a
// request-list reference model.
module tb_reg_writeback_seq;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 64;

    logic              Clk;
    logic              Reset;
    logic              ReqValid;
    logic              ReqReady;
    logic [4:0]        ReqRd0;
    logic [DATA_W-1:0] ReqData0;
    logic              ReqPair;
    logic [4:0]        ReqRd1;
    logic [DATA_W-1:0] ReqData1;
    logic [4:0]        RW;
    logic [DATA_W-1:0] BusW;
    logic              RegWr;
    logic [31:0]       Pending;
    logic              Busy;

    reg_writeback_seq #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqRd0   (ReqRd0),
        .ReqData0 (ReqData0),
        .ReqPair  (ReqPair),
        .ReqRd1   (ReqRd1),
        .ReqData1 (ReqData1),
        .RW       (RW),
        .BusW     (BusW),
        .RegWr    (RegWr),
        .Pending  (Pending),
        .Busy     (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Each queued request is the list of register writes it still owes.
    typedef struct {
        int          n;
        int          idx;
        logic [4:0]  wrd0;
        logic [4:0]  wrd1;
        logic [63:0] wd0;
        logic [63:0] wd1;
    } req_t;

    req_t        q[$];
    logic        m_wr;
    logic [4:0]  m_rw;
    logic [63:0] m_busw;
    logic [63:0] m_x[32];
    int          vectors;
    int          miscompares;
    int          cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic v, input logic [4:0] r0,
                              input logic [63:0] d0, input logic p, input logic [4:0] r1,
                              input logic [63:0] d1, output logic acc);
        req_t h;
        req_t nr;
        acc = 1'b0;
        if (rst) begin
            q.delete();
            m_wr   = 1'b0;
            m_rw   = 5'd31;
            m_busw = '0;
            return;
        end
        acc  = v && (q.size() < DEPTH);
        m_wr = 1'b0;
        if (q.size() > 0) begin
            h = q[0];
            if (h.n == 0) begin
                void'(q.pop_front());
            end else begin
                m_wr   = 1'b1;
                m_rw   = (h.idx == 0) ? h.wrd0 : h.wrd1;
                m_busw = (h.idx == 0) ? h.wd0  : h.wd1;
                h.idx++;
                if (h.idx == h.n) void'(q.pop_front());
                else              q[0] = h;
            end
        end
        if (acc) begin
            nr.n = 0; nr.idx = 0;
            nr.wrd0 = '0; nr.wrd1 = '0; nr.wd0 = '0; nr.wd1 = '0;
            if (r0 != 5'd31) begin
                nr.wrd0 = r0; nr.wd0 = d0; nr.n = 1;
            end
            if (p && r1 != 5'd31) begin
                if (nr.n == 0) begin nr.wrd0 = r1; nr.wd0 = d1; end
                else           begin nr.wrd1 = r1; nr.wd1 = d1; end
                nr.n++;
            end
            q.push_back(nr);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] pm;
        pm = '0;
        for (int e = 0; e < q.size(); e++)
            for (int k = q[e].idx; k < q[e].n; k++)
                pm[(k == 0) ? q[e].wrd0 : q[e].wrd1] = 1'b1;
        if (m_wr) pm[m_rw] = 1'b1;
        return pm;
    endfunction

    task automatic cycle(input logic rst, input logic v, input logic [4:0] r0,
                         input logic [63:0] d0, input logic p, input logic [4:0] r1,
                         input logic [63:0] d1, output logic acc);
        Reset    = rst;
        ReqValid = v;
        ReqRd0   = r0;
        ReqData0 = d0;
        ReqPair  = p;
        ReqRd1   = r1;
        ReqData1 = d1;
        @(posedge Clk);
        model_step(rst, v, r0, d0, p, r1, d1, acc);
        @(negedge Clk);
        cyc++;
        if (m_wr) m_x[m_rw] = m_busw;
        check("RegWr",    {63'd0, RegWr},    {63'd0, m_wr});
        check("RW",       {59'd0, RW},       {59'd0, m_rw});
        check("BusW",     BusW,              m_busw);
        check("Pending",  {32'd0, Pending},  {32'd0, model_pending()});
        check("Busy",     {63'd0, Busy},     {63'd0, (q.size() > 0) || m_wr});
        check("ReqReady", {63'd0, ReqReady}, {63'd0, q.size() < DEPTH});
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, a);
    endtask

    // Holds a request on the inputs until it is accepted (bounded).
    task automatic send(input logic [4:0] r0, input logic [63:0] d0, input logic p,
                        input logic [4:0] r1, input logic [63:0] d1);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 32 && !a; i++) cycle(1'b0, 1'b1, r0, d0, p, r1, d1, a);
        if (!a) check("accept_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [4:0] pick_rd();
        int unsigned s;
        s = $urandom_range(0, 7);
        if (s == 0) return 5'd31;
        if (s < 4)  return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 30));
    endfunction

    initial begin
        logic        a;
        logic        hold;
        logic [4:0]  r0, r1;
        logic [63:0] d0, d1;
        logic        p;
        int unsigned vprob;
        vectors = 0; miscompares = 0; cyc = 0;
        m_wr = 1'b0; m_rw = 5'd31; m_busw = '0;
        for (int i = 0; i < 32; i++) m_x[i] = '0;

        cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, a);
        cycle(1'b1, 1'b1, 5'd4, 64'h55, 1'b0, 5'd0, '0, a);

        send(5'd3, 64'hDEADBEEF, 1'b0, 5'd0, '0);
        idle(3);
        check("X3", m_x[3], 64'hDEADBEEF);
        send(5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
        idle(3);
        send(5'd31, 64'h99, 1'b1, 5'd5, 64'h55);
        send(5'd31, 64'h77, 1'b0, 5'd9, 64'h88);
        idle(3);
        for (int k = 0; k < 6; k++)
            send(5'(2*k + 8), 64'(k), 1'b1, 5'(2*k + 9), 64'(k + 100));
        idle(14);
        for (int k = 0; k < 3; k++)
            send(5'(k + 1), 64'(k + 200), 1'b1, 5'(k + 20), 64'(k + 300));
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, a);
        idle(4);
        send(5'd7, 64'hA, 1'b1, 5'd7, 64'hB);
        idle(3);
        check("X7", m_x[7], 64'hB);
        check("X31", m_x[31], 64'd0);

        hold = 1'b0; vprob = 50;
        r0 = '0; r1 = '0; d0 = '0; d1 = '0; p = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (c % 100 == 0) vprob = $urandom_range(10, 100);
            if (!hold) begin
                r0 = pick_rd(); r1 = pick_rd();
                d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
                p  = 1'($urandom_range(0, 1));
                hold = ($urandom_range(1, 100) <= vprob);
            end
            cycle(($urandom_range(0, 199) == 0), hold, r0, d0, p, r1, d1, a);
            if (a || Reset) hold = 1'b0;
        end
        idle(12);
        check("X31_final", m_x[31], 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
